// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I datapath and hazard_ctrl.
// The datapath side presents pipeline instructions/types and receives forwarding and stall/flush controls.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ID_EX_IR;
    logic [31:0]      EX_MEM_IR;
    logic [31:0]      MEM_WB_IR;
    logic [2:0]       ID_EX_type;
    logic [2:0]       EX_MEM_type;
    logic [2:0]       MEM_WB_type;
    logic             branch_taken;
    logic             dmem_ready;
    logic [1:0]       EX_MEM_FW;
    logic [1:0]       MEM_WB_FW;
    logic             STALL;
    logic             FLUSH;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ID_EX_IR, EX_MEM_IR, MEM_WB_IR,
        output ID_EX_type, EX_MEM_type, MEM_WB_type,
        output branch_taken, dmem_ready,
        input  EX_MEM_FW, MEM_WB_FW, STALL, FLUSH, bus_err, stall_cycles
    );

    modport slave (
        input  ID_EX_IR, EX_MEM_IR, MEM_WB_IR,
        input  ID_EX_type, EX_MEM_type, MEM_WB_type,
        input  branch_taken, dmem_ready,
        output EX_MEM_FW, MEM_WB_FW, STALL, FLUSH, bus_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: operand forwarding, load-use and
// data-memory wait stalls with timeout, fixed-length branch flush, stall-cycle counter.
module hazard_ctrl #(
    parameter int TIMEOUT      = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input logic         clk1,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam logic [2:0] T_LOAD  = 3'd2;
    localparam logic [2:0] T_STORE = 3'd3;
    localparam int         WAIT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {RUN, LDUSE, MEMWAIT} state_t;

    function automatic logic is_writer(input logic [2:0] t);
        return (t == 3'd0) || (t == 3'd1) || (t == 3'd2) || (t == 3'd5) || (t == 3'd6);
    endfunction

    function automatic logic uses_rs1(input logic [2:0] t, input logic [31:0] ir);
        return (t <= 3'd4) || ((t == 3'd5) && (ir[6:0] == 7'b1100111));
    endfunction

    function automatic logic uses_rs2(input logic [2:0] t);
        return (t == 3'd0) || (t == 3'd3) || (t == 3'd4);
    endfunction

    state_t             state_reg;
    logic               ld_done_reg;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic [2:0]         flush_cnt_reg;
    logic [CNT_W-1:0]   stall_cnt_reg;

    logic [4:0] ex_rd, wb_rd;
    logic [4:0] id_src [2];
    logic [1:0] id_uses;
    logic [1:0] ex_match, ex_fw, wb_fw;
    logic       ex_wr_ok, wb_wr_ok;
    logic       lduse_hit, mem_busy, timeout_hit, stall_c;
    logic       unused_ir_bits;

    assign ex_rd      = hz.EX_MEM_IR[11:7];
    assign wb_rd      = hz.MEM_WB_IR[11:7];
    assign id_src[1]  = hz.ID_EX_IR[19:15];
    assign id_src[0]  = hz.ID_EX_IR[24:20];
    assign id_uses[1] = uses_rs1(hz.ID_EX_type, hz.ID_EX_IR);
    assign id_uses[0] = uses_rs2(hz.ID_EX_type);
    assign ex_wr_ok   = is_writer(hz.EX_MEM_type) && (ex_rd != 5'd0);
    assign wb_wr_ok   = is_writer(hz.MEM_WB_type) && (wb_rd != 5'd0);

    // Bit 1 compares against rs1, bit 0 against rs2.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign ex_match[gi] = ex_wr_ok && (ex_rd == id_src[gi]) && id_uses[gi];
            assign ex_fw[gi]    = ex_match[gi] && (hz.EX_MEM_type != T_LOAD);
            assign wb_fw[gi]    = wb_wr_ok && (wb_rd == id_src[gi]) && id_uses[gi];
        end
    endgenerate

    assign hz.EX_MEM_FW = ex_fw;
    assign hz.MEM_WB_FW = wb_fw;

    assign lduse_hit   = (hz.EX_MEM_type == T_LOAD) && (|ex_match);
    assign mem_busy    = ((hz.EX_MEM_type == T_LOAD) || (hz.EX_MEM_type == T_STORE)) && !hz.dmem_ready;
    assign timeout_hit = (state_reg == MEMWAIT) && !hz.dmem_ready &&
                         (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        stall_c = 1'b0;
        unique case (state_reg)
            RUN:     stall_c = mem_busy || (lduse_hit && !ld_done_reg);
            LDUSE:   stall_c = 1'b0;
            MEMWAIT: stall_c = !hz.dmem_ready;
            default: stall_c = 1'b0;
        endcase
    end

    // STALL is partly input-driven, so it is masked while reset is held.
    assign hz.STALL        = stall_c && rst_n;
    assign hz.bus_err      = timeout_hit;
    assign hz.FLUSH        = (flush_cnt_reg != 3'd0);
    assign hz.stall_cycles = stall_cnt_reg;
    assign unused_ir_bits  = ^{hz.ID_EX_IR, hz.EX_MEM_IR, hz.MEM_WB_IR};

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            ld_done_reg   <= 1'b0;
            wait_cnt_reg  <= '0;
            flush_cnt_reg <= 3'd0;
            stall_cnt_reg <= '0;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (!stall_c)
                        ld_done_reg <= 1'b0;
                    if (mem_busy) begin
                        state_reg    <= MEMWAIT;
                        wait_cnt_reg <= WAIT_W'(1);
                    end else if (lduse_hit && !ld_done_reg) begin
                        state_reg <= LDUSE;
                    end
                end
                LDUSE: begin
                    ld_done_reg <= 1'b1;
                    state_reg   <= RUN;
                end
                MEMWAIT: begin
                    if (hz.dmem_ready || timeout_hit) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                default: state_reg <= RUN;
            endcase

            // The flush window only advances on cycles the front end actually moves.
            if (!stall_c) begin
                if (hz.branch_taken)
                    flush_cnt_reg <= 3'(FLUSH_CYCLES);
                else if (flush_cnt_reg != 3'd0)
                    flush_cnt_reg <= flush_cnt_reg - 3'd1;
            end

            if (stall_c && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: forwarding vector table plus stall/flush/reset sequences.
module tb_hazard_ctrl;
    localparam int TO = 16;
    localparam int FC = 2;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_H    = 7'b1110011;

    logic clk1 = 1'b0;
    logic rst_n;
    always #5 clk1 = ~clk1;

    hazard_ctrl_if #(.CNT_W(32)) hz ();
    hazard_ctrl #(.TIMEOUT(TO), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk1 (clk1),
        .rst_n(rst_n),
        .hz   (hz)
    );

    typedef struct {
        logic [31:0] id_ir, ex_ir, wb_ir;
        logic [2:0]  id_t, ex_t, wb_t;
        logic [1:0]  e_ex, e_wb;
    } vec_t;

    typedef struct {
        logic [1:0]  ex, wb;
        logic        st, fl, be;
        logic [31:0] sc;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[12];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_step   = 0;
    logic [31:0] model_cnt = 0;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pipe(input logic [31:0] id_ir, input logic [2:0] id_t,
                            input logic [31:0] ex_ir, input logic [2:0] ex_t,
                            input logic [31:0] wb_ir, input logic [2:0] wb_t);
        hz.ID_EX_IR  = id_ir;  hz.ID_EX_type  = id_t;
        hz.EX_MEM_IR = ex_ir;  hz.EX_MEM_type = ex_t;
        hz.MEM_WB_IR = wb_ir;  hz.MEM_WB_type = wb_t;
    endtask

    task automatic idle();
        set_pipe(enc(OP_I, 0, 0, 0), 3'd1, enc(OP_I, 0, 0, 0), 3'd1, enc(OP_I, 0, 0, 0), 3'd1);
        hz.branch_taken = 1'b0;
        hz.dmem_ready   = 1'b1;
    endtask

    // One clock: queue the expectation, compare on the falling edge, advance past the rising edge.
    task automatic step(input logic [1:0] e_ex, input logic [1:0] e_wb,
                        input logic e_st, input logic e_fl, input logic e_be);
        exp_t e;
        e.ex = e_ex; e.wb = e_wb; e.st = e_st; e.fl = e_fl; e.be = e_be; e.sc = model_cnt;
        sb_q.push_back(e);
        if (e_st) model_cnt = model_cnt + 1;
        @(negedge clk1);
        e = sb_q.pop_front();
        check("EX_MEM_FW", 32'(hz.EX_MEM_FW), 32'(e.ex));
        check("MEM_WB_FW", 32'(hz.MEM_WB_FW), 32'(e.wb));
        check("STALL", 32'(hz.STALL), 32'(e.st));
        check("FLUSH", 32'(hz.FLUSH), 32'(e.fl));
        check("bus_err", 32'(hz.bus_err), 32'(e.be));
        check("stall_cycles", hz.stall_cycles, e.sc);
        $display("step %0d: exfw=%b wbfw=%b STALL=%b FLUSH=%b bus_err=%b stall_cycles=%0d",
                 n_step, hz.EX_MEM_FW, hz.MEM_WB_FW, hz.STALL, hz.FLUSH, hz.bus_err, hz.stall_cycles);
        n_step++;
        @(posedge clk1);
        #1;
    endtask

    initial begin
        vecs[0]  = '{enc(OP_R, 1, 5, 5), enc(OP_R, 5, 1, 2), enc(OP_R, 9, 1, 2), 3'd0, 3'd0, 3'd0, 2'b11, 2'b00};
        vecs[1]  = '{enc(OP_R, 1, 0, 0), enc(OP_R, 0, 1, 2), enc(OP_R, 9, 1, 2), 3'd0, 3'd0, 3'd0, 2'b00, 2'b00};
        vecs[2]  = '{enc(OP_R, 1, 6, 3), enc(OP_R, 3, 1, 2), enc(OP_LD, 6, 1, 0), 3'd0, 3'd0, 3'd2, 2'b01, 2'b10};
        vecs[3]  = '{enc(OP_ST, 9, 4, 4), enc(OP_R, 4, 1, 2), enc(OP_I, 4, 1, 0), 3'd3, 3'd0, 3'd1, 2'b11, 2'b11};
        vecs[4]  = '{enc(OP_JAL, 1, 4, 4), enc(OP_R, 4, 1, 2), enc(OP_R, 4, 1, 2), 3'd5, 3'd0, 3'd0, 2'b00, 2'b00};
        vecs[5]  = '{enc(OP_JALR, 1, 4, 4), enc(OP_R, 4, 1, 2), enc(OP_I, 4, 1, 0), 3'd5, 3'd0, 3'd1, 2'b10, 2'b10};
        vecs[6]  = '{enc(OP_R, 1, 4, 4), enc(OP_ST, 4, 1, 2), enc(OP_H, 4, 4, 4), 3'd0, 3'd3, 3'd7, 2'b00, 2'b00};
        vecs[7]  = '{enc(OP_LUI, 1, 4, 4), enc(OP_R, 4, 1, 2), enc(OP_R, 4, 1, 2), 3'd6, 3'd0, 3'd0, 2'b00, 2'b00};
        vecs[8]  = '{enc(OP_I, 1, 1, 4), enc(OP_R, 4, 1, 2), enc(OP_I, 1, 2, 0), 3'd1, 3'd0, 3'd1, 2'b00, 2'b10};
        vecs[9]  = '{enc(OP_BR, 0, 2, 3), enc(OP_LUI, 3, 0, 0), enc(OP_JAL, 2, 0, 0), 3'd4, 3'd6, 3'd5, 2'b01, 2'b10};
        vecs[10] = '{enc(OP_H, 4, 4, 4), enc(OP_R, 4, 1, 2), enc(OP_R, 4, 1, 2), 3'd7, 3'd0, 3'd0, 2'b00, 2'b00};
        vecs[11] = '{enc(OP_R, 1, 7, 8), enc(OP_R, 7, 1, 2), enc(OP_R, 8, 1, 2), 3'd0, 3'd0, 3'd0, 2'b10, 2'b01};

        rst_n = 1'b0;
        idle();
        #12;
        check("reset STALL", 32'(hz.STALL), 32'd0);
        check("reset FLUSH", 32'(hz.FLUSH), 32'd0);
        check("reset bus_err", 32'(hz.bus_err), 32'd0);
        check("reset stall_cycles", hz.stall_cycles, 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1);
        #1;

        // Forwarding table in steady RUN.
        for (int i = 0; i < 12; i++) begin
            set_pipe(vecs[i].id_ir, vecs[i].id_t, vecs[i].ex_ir, vecs[i].ex_t, vecs[i].wb_ir, vecs[i].wb_t);
            step(vecs[i].e_ex, vecs[i].e_wb, 1'b0, 1'b0, 1'b0);
        end

        // Load-use: one stall, frozen load not re-detected, then detection re-armed.
        set_pipe(enc(OP_R, 1, 2, 7), 3'd0, enc(OP_LD, 7, 3, 0), 3'd2, enc(OP_I, 0, 0, 0), 3'd1);
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        hz.MEM_WB_IR = enc(OP_LD, 7, 3, 0); hz.MEM_WB_type = 3'd2;
        step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        hz.EX_MEM_IR = enc(OP_I, 0, 0, 0); hz.EX_MEM_type = 3'd1;
        step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        hz.EX_MEM_IR = enc(OP_LD, 7, 3, 0); hz.EX_MEM_type = 3'd2;
        hz.MEM_WB_IR = enc(OP_I, 0, 0, 0);  hz.MEM_WB_type = 3'd1;
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        idle();
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Store waits three cycles, then completes.
        hz.EX_MEM_IR = enc(OP_ST, 0, 2, 3); hz.EX_MEM_type = 3'd3; hz.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        hz.dmem_ready = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        idle();

        // Load with memory never ready: timeout.
        hz.EX_MEM_IR = enc(OP_LD, 8, 3, 0); hz.EX_MEM_type = 3'd2; hz.dmem_ready = 1'b0;
        for (int i = 1; i <= TO; i++) step(2'b00, 2'b00, 1'b1, 1'b0, (i == TO));
        idle();
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Plain branch flush.
        hz.branch_taken = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        hz.branch_taken = 1'b0;
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Flush held across a three-cycle memory wait.
        hz.branch_taken = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        hz.branch_taken = 1'b0;
        hz.EX_MEM_IR = enc(OP_ST, 0, 2, 3); hz.EX_MEM_type = 3'd3; hz.dmem_ready = 1'b0;
        step(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        hz.dmem_ready = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        idle();
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Branch presented while stalled is ignored.
        hz.EX_MEM_IR = enc(OP_ST, 0, 2, 3); hz.EX_MEM_type = 3'd3; hz.dmem_ready = 1'b0;
        hz.branch_taken = 1'b1;
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        hz.branch_taken = 1'b0; hz.dmem_ready = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        idle();
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // A second branch while counting reloads the window.
        hz.branch_taken = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        hz.branch_taken = 1'b0;
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a memory wait with a flush pending.
        hz.branch_taken = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        hz.branch_taken = 1'b0;
        hz.EX_MEM_IR = enc(OP_ST, 0, 2, 3); hz.EX_MEM_type = 3'd3; hz.dmem_ready = 1'b0;
        step(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async STALL", 32'(hz.STALL), 32'd0);
        check("async FLUSH", 32'(hz.FLUSH), 32'd0);
        check("async bus_err", 32'(hz.bus_err), 32'd0);
        check("async stall_cycles", hz.stall_cycles, 32'd0);
        model_cnt = 0;
        @(posedge clk1);
        #1;
        check("held STALL", 32'(hz.STALL), 32'd0);
        @(negedge clk1);
        idle();
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        hz.EX_MEM_IR = enc(OP_ST, 0, 2, 3); hz.EX_MEM_type = 3'd3; hz.dmem_ready = 1'b0;
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        hz.dmem_ready = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        idle();
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
